// File: rtl/umi_crossbar_nxn.sv
// Non-blocking NxN UMI crossbar: per-output fixed-priority or round-robin arbiter with
// stall lock, combinational payload mux, and ready steering back to the granted input.
module umi_crossbar_nxn #(
   parameter int N  = 2,
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 256
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic [1:0]        mode,
   input  logic [N*N-1:0]    mask,
   input  logic [N*N-1:0]    umi_in_request,
   output logic [N-1:0]      umi_in_ready,
   input  logic [N*CW-1:0]   umi_in_cmd,
   input  logic [N*AW-1:0]   umi_in_dstaddr,
   input  logic [N*AW-1:0]   umi_in_srcaddr,
   input  logic [N*DW-1:0]   umi_in_data,
   output logic [N-1:0]      umi_out_valid,
   input  logic [N-1:0]      umi_out_ready,
   output logic [N*CW-1:0]   umi_out_cmd,
   output logic [N*AW-1:0]   umi_out_dstaddr,
   output logic [N*AW-1:0]   umi_out_srcaddr,
   output logic [N*DW-1:0]   umi_out_data
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0][N-1:0] req_col;   // req_col[j][i]: effective request of input i for output j
   logic [N-1:0][N-1:0] gnt;       // gnt[j][i]: one-hot grant per output
   logic [N-1:0][IW-1:0] win_idx;
   logic                 rr_en;

   logic [N-1:0]         lock_q, lock_d;
   logic [N-1:0][IW-1:0] lock_idx_q, lock_idx_d;
   logic [N-1:0][IW-1:0] ptr_q, ptr_d;

   assign rr_en = mode[0] ^ mode[1];

   always_comb begin
      req_col = '0;
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < N; i++) begin
            req_col[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i];
         end
      end
   end

   // A held lock wins first; otherwise scan inputs starting at the pointer (or at 0).
   always_comb begin : p_arb
      logic        found;
      logic [IW:0] tgt;
      gnt     = '0;
      win_idx = '0;
      found   = 1'b0;
      tgt     = '0;
      for (int j = 0; j < N; j++) begin
         found = 1'b0;
         if (lock_q[j] && req_col[j][lock_idx_q[j]]) begin
            gnt[j][lock_idx_q[j]] = 1'b1;
            win_idx[j]            = lock_idx_q[j];
            found                 = 1'b1;
         end
         for (int k = 0; k < N; k++) begin
            tgt = rr_en ? ({1'b0, ptr_q[j]} + (IW+1)'(k)) : (IW+1)'(k);
            if (tgt >= (IW+1)'(N)) tgt = tgt - (IW+1)'(N);
            for (int i = 0; i < N; i++) begin
               if (!found && req_col[j][i] && (tgt == (IW+1)'(i))) begin
                  gnt[j][i]  = 1'b1;
                  win_idx[j] = IW'(i);
                  found      = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      umi_out_valid   = '0;
      umi_in_ready    = '0;
      umi_out_cmd     = '0;
      umi_out_dstaddr = '0;
      umi_out_srcaddr = '0;
      umi_out_data    = '0;
      for (int j = 0; j < N; j++) begin
         umi_out_valid[j] = |req_col[j];
         for (int i = 0; i < N; i++) begin
            umi_in_ready[i] = umi_in_ready[i] | (gnt[j][i] & umi_out_ready[j]);
            if (gnt[j][i]) begin
               umi_out_cmd[j*CW+:CW]     = umi_in_cmd[i*CW+:CW];
               umi_out_dstaddr[j*AW+:AW] = umi_in_dstaddr[i*AW+:AW];
               umi_out_srcaddr[j*AW+:AW] = umi_in_srcaddr[i*AW+:AW];
               umi_out_data[j*DW+:DW]    = umi_in_data[i*DW+:DW];
            end
         end
      end
   end

   // A stalled output locks onto its winner; a completed transfer moves the pointer past it.
   always_comb begin
      lock_d     = '0;
      lock_idx_d = '0;
      ptr_d      = ptr_q;
      for (int j = 0; j < N; j++) begin
         lock_d[j]     = umi_out_valid[j] & ~umi_out_ready[j];
         lock_idx_d[j] = win_idx[j];
         if (umi_out_valid[j] && umi_out_ready[j]) begin
            ptr_d[j] = (win_idx[j] == IW'(N - 1)) ? '0 : win_idx[j] + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         lock_q     <= '0;
         lock_idx_q <= '0;
         ptr_q      <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
      end
   end

endmodule

// File: tb/tb_umi_crossbar_nxn.sv
// Directed bench for umi_crossbar_nxn (N=4): vector table plus hand-written
// round-robin, lock and asynchronous-reset sequences.
module tb_umi_crossbar_nxn;

   localparam int N  = 4;
   localparam int CW = 32;
   localparam int AW = 64;
   localparam int DW = 256;

   logic              clk = 1'b0;
   logic              nreset;
   logic [1:0]        mode;
   logic [N*N-1:0]    mask;
   logic [N*N-1:0]    umi_in_request;
   logic [N-1:0]      umi_in_ready;
   logic [N*CW-1:0]   umi_in_cmd;
   logic [N*AW-1:0]   umi_in_dstaddr;
   logic [N*AW-1:0]   umi_in_srcaddr;
   logic [N*DW-1:0]   umi_in_data;
   logic [N-1:0]      umi_out_valid;
   logic [N-1:0]      umi_out_ready;
   logic [N*CW-1:0]   umi_out_cmd;
   logic [N*AW-1:0]   umi_out_dstaddr;
   logic [N*AW-1:0]   umi_out_srcaddr;
   logic [N*DW-1:0]   umi_out_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   umi_crossbar_nxn #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .mode            (mode),
      .mask            (mask),
      .umi_in_request  (umi_in_request),
      .umi_in_ready    (umi_in_ready),
      .umi_in_cmd      (umi_in_cmd),
      .umi_in_dstaddr  (umi_in_dstaddr),
      .umi_in_srcaddr  (umi_in_srcaddr),
      .umi_in_data     (umi_in_data),
      .umi_out_valid   (umi_out_valid),
      .umi_out_ready   (umi_out_ready),
      .umi_out_cmd     (umi_out_cmd),
      .umi_out_dstaddr (umi_out_dstaddr),
      .umi_out_srcaddr (umi_out_srcaddr),
      .umi_out_data    (umi_out_data)
   );

   // Payload of input i; index -1 means no grant (all-zero fields).
   function automatic logic [CW-1:0] f_cmd(int i);
      return (i < 0) ? '0 : (32'hC0DE_0000 | 32'(i));
   endfunction
   function automatic logic [AW-1:0] f_dst(int i);
      return (i < 0) ? '0 : {32'hD57A_0000, 32'(i)};
   endfunction
   function automatic logic [AW-1:0] f_src(int i);
      return (i < 0) ? '0 : {32'h5CA0_0000, 32'h0000_1000 + 32'(i)};
   endfunction
   function automatic logic [DW-1:0] f_data(int i);
      return (i < 0) ? '0 : {32'hDA7A_0000 + 32'(i), 192'h0, 32'h0000_00A0 + 32'(i)};
   endfunction

   function automatic logic [N*N-1:0] r(int i, int j);
      return 16'(1) << (j*N + i);
   endfunction

   typedef struct {
      logic [1:0]     mode;
      logic [N*N-1:0] mask;
      logic [N*N-1:0] req;
      logic [N-1:0]   ordy;
      logic [N-1:0]   ovld;
      logic [N-1:0]   irdy;
      int             w0, w1, w2, w3;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_port(input string tag, input int j, input int win);
      chk($sformatf("%s cmd[%0d]", tag, j), DW'(umi_out_cmd[j*CW+:CW]), DW'(f_cmd(win)));
      chk($sformatf("%s dst[%0d]", tag, j), DW'(umi_out_dstaddr[j*AW+:AW]), DW'(f_dst(win)));
      chk($sformatf("%s src[%0d]", tag, j), DW'(umi_out_srcaddr[j*AW+:AW]), DW'(f_src(win)));
      chk($sformatf("%s data[%0d]", tag, j), umi_out_data[j*DW+:DW], f_data(win));
   endtask

   task automatic expect_state(input string tag, input logic [N-1:0] ovld, input logic [N-1:0] irdy,
                               input int w0, input int w1, input int w2, input int w3);
      chk({tag, " out_valid"}, DW'(umi_out_valid), DW'(ovld));
      chk({tag, " in_ready"}, DW'(umi_in_ready), DW'(irdy));
      check_port(tag, 0, w0);
      check_port(tag, 1, w1);
      check_port(tag, 2, w2);
      check_port(tag, 3, w3);
   endtask

   task automatic drive(input logic [1:0] md, input logic [N*N-1:0] mk,
                        input logic [N*N-1:0] rq, input logic [N-1:0] ordy);
      mode           = md;
      mask           = mk;
      umi_in_request = rq;
      umi_out_ready  = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      umi_in_request = '0;
      nreset = 1'b0;
      #3;
      nreset = 1'b1;
      step();
   endtask

   initial begin
      int order[3];
      nreset = 1'b0;
      drive(2'b00, '0, '0, 4'hF);
      for (int i = 0; i < N; i++) begin
         umi_in_cmd[i*CW+:CW]     = f_cmd(i);
         umi_in_dstaddr[i*AW+:AW] = f_dst(i);
         umi_in_srcaddr[i*AW+:AW] = f_src(i);
         umi_in_data[i*DW+:DW]    = f_data(i);
      end

      //            mode   mask     req                            ordy   ovld   irdy   w0  w1  w2  w3
      tbl[0]  = '{2'b00, '0,      '0,                             4'hF, 4'h0, 4'h0, -1, -1, -1, -1};
      tbl[1]  = '{2'b00, '0,      r(0,1)|r(2,1),                  4'hF, 4'h2, 4'h1, -1,  0, -1, -1};
      tbl[2]  = '{2'b00, '0,      r(2,1),                         4'hF, 4'h2, 4'h4, -1,  2, -1, -1};
      tbl[3]  = '{2'b00, '0,      r(0,3)|r(1,2)|r(2,1)|r(3,0),    4'hF, 4'hF, 4'hF,  3,  2,  1,  0};
      tbl[4]  = '{2'b00, r(2,0),  r(2,0),                         4'hF, 4'h0, 4'h0, -1, -1, -1, -1};
      tbl[5]  = '{2'b00, r(2,0),  r(2,0),                         4'hF, 4'h0, 4'h0, -1, -1, -1, -1};
      tbl[6]  = '{2'b00, '0,      r(2,0),                         4'hF, 4'h1, 4'h4,  2, -1, -1, -1};
      tbl[7]  = '{2'b11, '0,      r(1,0)|r(3,0),                  4'hF, 4'h1, 4'h2,  1, -1, -1, -1};
      tbl[8]  = '{2'b00, r(0,2),  r(0,2)|r(1,2),                  4'hF, 4'h4, 4'h2, -1, -1,  1, -1};
      tbl[9]  = '{2'b00, '0,      r(3,3),                         4'h7, 4'h8, 4'h0, -1, -1, -1,  3};
      tbl[10] = '{2'b00, '0,      r(3,3)|r(0,3),                  4'hF, 4'h8, 4'h8, -1, -1, -1,  3};
      tbl[11] = '{2'b00, '0,      r(0,3),                         4'hF, 4'h8, 4'h1, -1, -1, -1,  0};

      #12;
      expect_state("reset", 4'h0, 4'h0, -1, -1, -1, -1);
      @(negedge clk);
      nreset = 1'b1;
      step();

      for (int v = 0; v < 12; v++) begin
         drive(tbl[v].mode, tbl[v].mask, tbl[v].req, tbl[v].ordy);
         #2;
         expect_state($sformatf("vec%0d", v), tbl[v].ovld, tbl[v].irdy,
                      tbl[v].w0, tbl[v].w1, tbl[v].w2, tbl[v].w3);
         step();
      end

      // Round-robin on output 2 among inputs 0,1,3.
      do_reset();
      order[0] = 0; order[1] = 1; order[2] = 3;
      drive(2'b10, '0, r(0,2)|r(1,2)|r(3,2), 4'hF);
      for (int c = 0; c < 6; c++) begin
         #2;
         expect_state($sformatf("rr%0d", c), 4'h4, 4'b0001 << order[c%3], -1, -1, order[c%3], -1);
         step();
      end

      // Stalled grant on output 0 survives a higher-priority newcomer.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive(2'b00, '0, r(1,0) | ((c >= 2) ? r(0,0) : '0), 4'hE);
         #2;
         expect_state($sformatf("lock%0d", c), 4'h1, 4'h0, 1, -1, -1, -1);
         step();
      end
      drive(2'b00, '0, r(1,0)|r(0,0), 4'hF);
      #2;
      expect_state("lock_rel", 4'h1, 4'h2, 1, -1, -1, -1);
      step();
      drive(2'b00, '0, r(0,0), 4'hF);
      #2;
      expect_state("lock_next", 4'h1, 4'h1, 0, -1, -1, -1);
      step();

      // Pointer to input 3, stall there, then reset asynchronously mid-cycle.
      do_reset();
      drive(2'b01, '0, r(2,0), 4'hF);
      #2;
      expect_state("arst_pre", 4'h1, 4'h4, 2, -1, -1, -1);
      step();
      drive(2'b01, '0, r(0,0)|r(3,0), 4'hE);
      #2;
      expect_state("arst_ptr3", 4'h1, 4'h0, 3, -1, -1, -1);
      step();
      mode = 2'b00;
      #2;
      expect_state("arst_lock", 4'h1, 4'h0, 3, -1, -1, -1);
      nreset = 1'b0;
      #1;
      expect_state("arst_drop", 4'h1, 4'h0, 0, -1, -1, -1);
      mode = 2'b01;
      #1;
      expect_state("arst_ptr0", 4'h1, 4'h0, 0, -1, -1, -1);
      nreset = 1'b1;
      #1;
      expect_state("arst_rel", 4'h1, 4'h0, 0, -1, -1, -1);
      step();
      umi_out_ready = 4'hF;
      #2;
      expect_state("arst_xfer", 4'h1, 4'h1, 0, -1, -1, -1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
